// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary stream collector.
// Optional bound outputs are enabled with UNARY_COLLECTOR_BOUNDS_EN.
package unary_pkg;

    function automatic int count_width(int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } collector_state_t;

endpackage

// File: rtl/unary_stream_collector_if.sv
// Unary bit stream in, binary count out, both valid/ready.
// Optional bound outputs are enabled with UNARY_COLLECTOR_BOUNDS_EN.
interface unary_stream_collector_if #(
    parameter int COUNT_WIDTH = 6
);
    logic                   in_y;
    logic                   in_valid;
    logic                   in_ready;
    logic [COUNT_WIDTH-1:0] out_value;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_y,
        output in_valid,
        input  in_ready,
        input  out_value,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_y,
        input  in_valid,
        output in_ready,
        output out_value,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/unary_pop_counter.sv
// Frame bit counter paired with a ones counter.
// Optional bound outputs are enabled with UNARY_COLLECTOR_BOUNDS_EN.
module unary_pop_counter #(
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   bit_in,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic [COUNT_WIDTH-1:0] ones
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_count <= '0;
            ones      <= '0;
        end else if (clear) begin
            bit_count <= '0;
            ones      <= '0;
        end else if (inc) begin
            bit_count <= bit_count + COUNT_WIDTH'(1);
            ones      <= ones + COUNT_WIDTH'(bit_in);
        end
    end

endmodule

// File: rtl/unary_stream_collector.sv
// Counts ones over a frame of unary bits, hands the count downstream.
// Optional bound outputs are enabled with UNARY_COLLECTOR_BOUNDS_EN.
module unary_stream_collector
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    unary_stream_collector_if.slave bus,
`ifdef UNARY_COLLECTOR_BOUNDS_EN
    output logic [COUNT_WIDTH-1:0] lower_bound,
    output logic [COUNT_WIDTH-1:0] upper_bound,
`endif
    output logic                   overflow
);

    collector_state_t state_q;
    collector_state_t state_d;

    logic                   accept;
    logic                   last_bit;
    logic                   cnt_inc;
    logic                   cnt_clear;
    logic                   load_out;
    logic [COUNT_WIDTH-1:0] bit_count;
    logic [COUNT_WIDTH-1:0] ones;
    logic [COUNT_WIDTH-1:0] final_ones;

    assign bus.in_ready = (state_q != DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_bit     = (bit_count == COUNT_WIDTH'(INPUT_WIDTH - 1));
    assign final_ones   = ones + COUNT_WIDTH'(bus.in_y);

    unary_pop_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_pop (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_inc),
        .bit_in   (bus.in_y),
        .clear    (cnt_clear),
        .bit_count(bit_count),
        .ones     (ones)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // IDLE counters are always zero, so the first bit is a plain increment
    always_comb begin
        state_d   = state_q;
        cnt_inc   = 1'b0;
        cnt_clear = 1'b0;
        load_out  = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    cnt_inc = 1'b1;
                    if (last_bit) begin
                        load_out = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = COLLECT;
                    end
                end
            end
            DONE: begin
                if (bus.out_valid && bus.out_ready) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_value <= '0;
            bus.out_valid <= 1'b0;
        end else if (load_out) begin
            bus.out_value <= final_ones;
            bus.out_valid <= 1'b1;
        end else if (cnt_clear) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (bus.in_valid && !bus.in_ready) begin
            overflow <= 1'b1;
        end
    end

`ifdef UNARY_COLLECTOR_BOUNDS_EN
    assign lower_bound = ones;
    assign upper_bound = ones + COUNT_WIDTH'(INPUT_WIDTH) - bit_count;
`endif

endmodule

// File: tb/tb_unary_stream_collector.sv
// Directed bench for unary_stream_collector, widths 8 and 1.
// Bound checks compile in with UNARY_COLLECTOR_BOUNDS_EN.
module tb_unary_stream_collector;

    logic clk;
    logic rst_n;
    logic ovf8;
    logic ovf1;
    int   checks;
    int   failures;

`ifdef UNARY_COLLECTOR_BOUNDS_EN
    logic [3:0] lb8;
    logic [3:0] ub8;
    logic [0:0] lb1;
    logic [0:0] ub1;
`endif

    unary_stream_collector_if #(.COUNT_WIDTH(4)) bus8 ();
    unary_stream_collector_if #(.COUNT_WIDTH(1)) bus1 ();

    unary_stream_collector #(
        .INPUT_WIDTH(8)
    ) dut8 (
        .clk        (clk),
        .reset      (rst_n),
        .bus        (bus8.slave),
`ifdef UNARY_COLLECTOR_BOUNDS_EN
        .lower_bound(lb8),
        .upper_bound(ub8),
`endif
        .overflow   (ovf8)
    );

    unary_stream_collector #(
        .INPUT_WIDTH(1)
    ) dut1 (
        .clk        (clk),
        .reset      (rst_n),
        .bus        (bus1.slave),
`ifdef UNARY_COLLECTOR_BOUNDS_EN
        .lower_bound(lb1),
        .upper_bound(ub1),
`endif
        .overflow   (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit8(logic y);
        bus8.in_y     = y;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.in_y     = 1'b0;
    endtask

    task automatic frame8(logic [7:0] bits);
        for (int i = 0; i < 8; i++) bit8(bits[i]);
    endtask

    task automatic accept8();
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] f;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus8.in_y      = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        bus1.in_y      = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        chk("rst_in_ready", bus8.in_ready, 1);
        chk("rst_out_valid", bus8.out_valid, 0);
        chk("rst_out_value", bus8.out_value, 0);
        chk("rst_overflow", ovf8, 0);
`ifdef UNARY_COLLECTOR_BOUNDS_EN
        chk("rst_lower", lb8, 0);
        chk("rst_upper", ub8, 8);
`endif

        // frame 1,1,1,0,0,0,0,0
        f = 8'b0000_0111;
        for (int i = 0; i < 7; i++) bit8(f[i]);
        chk("t1_valid_early", bus8.out_valid, 0);
        bit8(f[7]);
        chk("t1_valid", bus8.out_valid, 1);
        chk("t1_value", bus8.out_value, 3);
        chk("t1_in_ready_done", bus8.in_ready, 0);
        accept8();
        chk("t1_valid_clr", bus8.out_valid, 0);
        chk("t1_in_ready", bus8.in_ready, 1);

        // all ones with gaps of 0..3 cycles
        for (int i = 0; i < 8; i++) begin
            bit8(1'b1);
            for (int g = 0; g < i % 4; g++) tick();
`ifdef UNARY_COLLECTOR_BOUNDS_EN
            chk("t2_lower_hold", lb8, i + 1);
`endif
        end
        chk("t2_valid", bus8.out_valid, 1);
        chk("t2_value", bus8.out_value, 8);
        accept8();

        // backpressure with stray bits
        frame8(8'b0000_0111);
        for (int c = 0; c < 5; c++) begin
            bus8.in_valid = (c == 1 || c == 3);
            tick();
            bus8.in_valid = 1'b0;
        end
        chk("t3_value", bus8.out_value, 3);
        chk("t3_valid", bus8.out_valid, 1);
        chk("t3_overflow", ovf8, 1);
        accept8();
        chk("t3_in_ready", bus8.in_ready, 1);
        frame8(8'h00);
        chk("t3_zero_valid", bus8.out_valid, 1);
        chk("t3_zero_value", bus8.out_value, 0);
        chk("t3_overflow_sticky", ovf8, 1);
        accept8();

        // async reset mid-frame
        for (int i = 0; i < 4; i++) bit8(1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_overflow", ovf8, 0);
        chk("t4_out_valid", bus8.out_valid, 0);
        chk("t4_out_value", bus8.out_value, 0);
        chk("t4_in_ready", bus8.in_ready, 1);
        #2 rst_n = 1'b1;
        tick();
        frame8(8'b0100_0100);
        chk("t4_valid", bus8.out_valid, 1);
        chk("t4_value", bus8.out_value, 2);
        accept8();

        // partial bounds, then a frame of five ones
        bit8(1'b1);
        bit8(1'b0);
        bit8(1'b1);
`ifdef UNARY_COLLECTOR_BOUNDS_EN
        chk("t5_lower_mid", lb8, 2);
        chk("t5_upper_mid", ub8, 7);
`endif
        bit8(1'b1);
        bit8(1'b1);
        bit8(1'b0);
        bit8(1'b1);
        bit8(1'b0);
        chk("t5_value", bus8.out_value, 5);
`ifdef UNARY_COLLECTOR_BOUNDS_EN
        chk("t5_lower_done", lb8, 5);
        chk("t5_upper_done", ub8, 5);
`endif
        accept8();

        // single-bit frames
        bus1.in_y     = 1'b1;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("t6_valid1", bus1.out_valid, 1);
        chk("t6_value1", bus1.out_value, 1);
        chk("t6_in_ready1", bus1.in_ready, 0);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        chk("t6_ready_again", bus1.in_ready, 1);
        bus1.in_y     = 1'b0;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("t6_valid0", bus1.out_valid, 1);
        chk("t6_value0", bus1.out_value, 0);
        chk("t6_overflow1", ovf1, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
